wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter and register scoreboard for the integer register file. Merges two write-back requesters (A: in-order pipeline write-back; B: long-latency unit such as LSU or mul/div) onto the register file's single write port through a registered output stage. Tracks which destination registers still have writes outstanding so decode can stall on RAW hazards. Sits between the write-back sources and the register file write port (`i_rd_addr` / `i_rd_data` / `i_rd_wren`).

## Interface
- MAX_WAIT, 4, consecutive cycles B may be refused before it gets priority; legal range 1–15.
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_a_valid  in  1  requester A has a write.
- i_a_addr  in  5  requester A destination register.
- i_a_data  in  32  requester A write data.
- o_a_ready  out  1  A accepted this cycle if `i_a_valid`.
- i_b_valid, i_b_addr, i_b_data  in  1/5/32  requester B, same meaning as A.
- o_b_ready  out  1  B accepted this cycle if `i_b_valid`.
- i_issue_valid  in  1  decode issues an instruction writing `i_issue_rd`.
- i_issue_rd  in  5  destination of the issued instruction.
- i_rs1_addr, i_rs2_addr  in  5  decode source registers.
- o_rs1_busy, o_rs2_busy  out  1  source has an outstanding write.
- o_rd_addr  out  5  to register file write address.
- o_rd_data  out  32  to register file write data.
- o_rd_wren  out  1  to register file write enable.

## Operation
- Handshake: a transfer occurs when valid and ready are both high on a rising edge. At most one requester is accepted per cycle. Valid must stay high with address and data stable until accepted.
- Grant (combinational):
  - Default priority is A.
  - When `wait_cnt == MAX_WAIT` and `i_b_valid`, B has priority.
  - The winner's ready is 1 and the loser's ready is 0.
  - If only one requester is valid, it gets ready.
  - Ready is 0 for a requester whose valid is low.
- `wait_cnt` (width $clog2(MAX_WAIT+1)):
  - Increments, saturating at MAX_WAIT, each cycle B is valid and not accepted.
  - Clears on B acceptance or whenever `i_b_valid` is 0.
- Output stage, registered:
  - On acceptance, `o_rd_addr` and `o_rd_data` load the winner's address and data.
  - `o_rd_wren` loads 1, unless the address is 0; an address-0 write is accepted and dropped with `o_rd_wren` = 0.
  - With no acceptance, `o_rd_wren` goes to 0; `o_rd_addr` and `o_rd_data` hold.
- Scoreboard, a 32-bit `busy` vector:
  - Set: `i_issue_valid` with `i_issue_rd != 0` sets `busy[i_issue_rd]` at the edge.
  - Clear: `o_rd_wren` high clears `busy[o_rd_addr]` at that edge. This is the same edge on which the register file commits.
  - Set and clear of the same index in one cycle: set wins, because a new producer was issued.
  - `busy[0]` is always 0.
- Busy lookup (combinational):
  - `o_rs1_busy = busy[i_rs1_addr]` and `o_rs2_busy = busy[i_rs2_addr]`.
  - Both are 0 for address 0.
- The block does not check that a write matches an issued destination. A write to a non-busy register is passed through unchanged.

## Timing
- Reset (async assert, released on clock): `busy` = 0, `wait_cnt` = 0, `o_rd_wren` = 0, `o_rd_addr` = 0, `o_rd_data` = 0. Ready outputs follow the combinational rule.
- Reset mid-operation: the write held in the output stage is discarded (`o_rd_wren` forced 0) and all busy bits are cleared.
- Latency:
  - Acceptance at edge N makes `o_rd_wren` = 1 during cycle N+1; the register file writes at edge N+1.
  - The busy bit reads 0 from cycle N+2, when register file read data is already updated.
- Throughput: one write per cycle sustained.
- Worst-case B wait: MAX_WAIT cycles, then accepted on the next cycle regardless of A.
- Issue to busy: `i_issue_valid` at edge N makes busy visible in cycle N+1.

## Test plan
- Reset, then A writes `x5=0x1234_5678` with B idle → `o_a_ready`=1 same cycle; next cycle `o_rd_wren`=1, `o_rd_addr`=5, `o_rd_data`=0x12345678; following cycle `o_rd_wren`=0.
- Issue rd=7, then B writes `x7=0xDEAD_BEEF` two cycles later → `o_rs1_busy`=1 for `i_rs1_addr`=7 from the cycle after issue until two cycles after B acceptance, then 0.
- A and B valid continuously, MAX_WAIT=4 → A accepted for 4 cycles, B accepted on cycle 5, pattern repeats; no cycle accepts both.
- Issue rd=3 in the same cycle `o_rd_wren`=1 with `o_rd_addr`=3 → `busy[3]` remains 1.
- A writes `x0=0xFFFF_FFFF` → `o_a_ready`=1, `o_rd_wren` stays 0; `o_rs1_busy` for addr 0 always 0, even after issue rd=0.
- Assert `i_reset` mid-cycle while `o_rd_wren`=1 and busy bits 2 and 9 are set → `o_rd_wren`, `o_rd_addr` and `o_rd_data` go to 0 immediately; all busy outputs read 0; `wait_cnt` restarts from 0.

Source files
------------

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges requesters A and B onto the register-file write port
// through a registered output stage, and keeps the RAW busy scoreboard for decode.
module wb_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_a_valid,
  input  logic [4:0]  i_a_addr,
  input  logic [31:0] i_a_data,
  output logic        o_a_ready,
  input  logic        i_b_valid,
  input  logic [4:0]  i_b_addr,
  input  logic [31:0] i_b_data,
  output logic        o_b_ready,
  input  logic        i_issue_valid,
  input  logic [4:0]  i_issue_rd,
  input  logic [4:0]  i_rs1_addr,
  input  logic [4:0]  i_rs2_addr,
  output logic        o_rs1_busy,
  output logic        o_rs2_busy,
  output logic [4:0]  o_rd_addr,
  output logic [31:0] o_rd_data,
  output logic        o_rd_wren
);

  localparam int WCW = $clog2(MAX_WAIT + 1);
  localparam logic [WCW-1:0] WAIT_SAT = WCW'(MAX_WAIT);

  typedef struct packed {
    logic        valid;
    logic [4:0]  addr;
    logic [31:0] data;
  } wb_req_t;

  wb_req_t        req_a, req_b, win;
  logic [WCW-1:0] wait_cnt;
  logic           b_pri, grant_a, grant_b, accept;
  logic [31:0]    busy, busy_set, busy_clr;

  assign req_a = {i_a_valid, i_a_addr, i_a_data};
  assign req_b = {i_b_valid, i_b_addr, i_b_data};

  // B takes priority only once it has been refused MAX_WAIT cycles in a row.
  assign b_pri   = req_b.valid && (wait_cnt == WAIT_SAT);
  assign grant_a = req_a.valid && !b_pri;
  assign grant_b = req_b.valid && !grant_a;
  assign accept  = grant_a || grant_b;
  assign win     = grant_a ? req_a : req_b;

  assign o_a_ready = grant_a;
  assign o_b_ready = grant_b;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                    wait_cnt <= '0;
    else if (!i_b_valid || grant_b) wait_cnt <= '0;
    else if (wait_cnt != WAIT_SAT)  wait_cnt <= wait_cnt + WCW'(1);
  end

  // x0 writes are accepted but never reach the register file.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_rd_wren <= 1'b0;
      o_rd_addr <= '0;
      o_rd_data <= '0;
    end else begin
      o_rd_wren <= accept && (win.addr != 5'd0);
      if (accept) begin
        o_rd_addr <= win.addr;
        o_rd_data <= win.data;
      end
    end
  end

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (i_issue_valid) busy_set[i_issue_rd] = 1'b1;
    if (o_rd_wren)     busy_clr[o_rd_addr]  = 1'b1;
  end

  // Set dominates clear: a same-cycle issue is a newer producer than the commit.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) busy <= '0;
    else         busy <= ((busy & ~busy_clr) | busy_set) & ~32'd1;
  end

  assign o_rs1_busy = busy[i_rs1_addr];
  assign o_rs2_busy = busy[i_rs2_addr];

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomized bench for wb_arbiter: behavioural model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_wb_arbiter;
  localparam int MAX_WAIT = 4;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_a_valid, i_b_valid, i_issue_valid;
  logic [4:0]  i_a_addr, i_b_addr, i_issue_rd, i_rs1_addr, i_rs2_addr;
  logic [31:0] i_a_data, i_b_data;
  logic        o_a_ready, o_b_ready, o_rs1_busy, o_rs2_busy, o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;

  wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_a_valid(i_a_valid), .i_a_addr(i_a_addr), .i_a_data(i_a_data), .o_a_ready(o_a_ready),
    .i_b_valid(i_b_valid), .i_b_addr(i_b_addr), .i_b_data(i_b_data), .o_b_ready(o_b_ready),
    .i_issue_valid(i_issue_valid), .i_issue_rd(i_issue_rd),
    .i_rs1_addr(i_rs1_addr), .i_rs2_addr(i_rs2_addr),
    .o_rs1_busy(o_rs1_busy), .o_rs2_busy(o_rs2_busy),
    .o_rd_addr(o_rd_addr), .o_rd_data(o_rd_data), .o_rd_wren(o_rd_wren)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Model state: consecutive refusals of B, pending register-file write, busy table.
  int          m_refused;
  bit          m_wren;
  bit [4:0]    m_addr;
  bit [31:0]   m_data;
  bit          m_busy [32];

  // Snapshot of the last cycle observed.
  logic        obs_a_ready, obs_b_ready, obs_wren, obs_rs1, obs_rs2;
  logic [4:0]  obs_addr;
  logic [31:0] obs_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_refused = 0;
    m_wren = 0;
    m_addr = 0;
    m_data = 0;
    foreach (m_busy[i]) m_busy[i] = 0;
  endtask

  function automatic bit busy_of(input bit [4:0] r);
    return (r == 0) ? 1'b0 : m_busy[r];
  endfunction

  // One clock cycle: compare at negedge, advance the model across the posedge.
  task automatic cyc();
    bit ea, eb;
    bit n_wren;
    bit [4:0] n_addr;
    bit [31:0] n_data;
    int n_refused;
    bit n_busy [32];
    @(negedge i_clk);
    obs_a_ready = o_a_ready; obs_b_ready = o_b_ready; obs_wren = o_rd_wren;
    obs_addr = o_rd_addr; obs_data = o_rd_data; obs_rs1 = o_rs1_busy; obs_rs2 = o_rs2_busy;
    eb = i_b_valid && (m_refused >= MAX_WAIT || !i_a_valid);
    ea = i_a_valid && !eb;
    chk("a_ready", {31'd0, o_a_ready}, {31'd0, ea});
    chk("b_ready", {31'd0, o_b_ready}, {31'd0, eb});
    chk("rd_wren", {31'd0, o_rd_wren}, {31'd0, m_wren});
    chk("rd_addr", {27'd0, o_rd_addr}, {27'd0, m_addr});
    chk("rd_data", o_rd_data, m_data);
    chk("rs1_busy", {31'd0, o_rs1_busy}, {31'd0, busy_of(i_rs1_addr)});
    chk("rs2_busy", {31'd0, o_rs2_busy}, {31'd0, busy_of(i_rs2_addr)});
    n_addr = m_addr; n_data = m_data; n_wren = 0;
    if (ea) begin n_addr = i_a_addr; n_data = i_a_data; n_wren = (i_a_addr != 0); end
    if (eb) begin n_addr = i_b_addr; n_data = i_b_data; n_wren = (i_b_addr != 0); end
    n_refused = (i_b_valid && !eb) ? ((m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT) : 0;
    n_busy = m_busy;
    if (m_wren) n_busy[m_addr] = 0;
    if (i_issue_valid && i_issue_rd != 0) n_busy[i_issue_rd] = 1;
    @(posedge i_clk);
    #1;
    m_wren = n_wren; m_addr = n_addr; m_data = n_data; m_refused = n_refused; m_busy = n_busy;
  endtask

  task automatic idle_inputs();
    i_a_valid = 0; i_a_addr = 0; i_a_data = 0;
    i_b_valid = 0; i_b_addr = 0; i_b_data = 0;
    i_issue_valid = 0; i_issue_rd = 0; i_rs1_addr = 0; i_rs2_addr = 0;
  endtask

  initial begin
    bit [9:0] pat;
    bit [4:0] pat5;
    int both;
    idle_inputs();
    i_reset = 1;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1 i_reset = 0;

    // Reset state
    i_rs1_addr = 5; i_rs2_addr = 9;
    cyc();
    chk("rst_wren", {31'd0, obs_wren}, 32'd0);
    chk("rst_addr", {27'd0, obs_addr}, 32'd0);
    chk("rst_data", obs_data, 32'd0);
    chk("rst_busy", {31'd0, obs_rs1 | obs_rs2}, 32'd0);

    // A writes x5
    i_a_valid = 1; i_a_addr = 5; i_a_data = 32'h1234_5678;
    cyc();
    chk("x5_ready", {31'd0, obs_a_ready}, 32'd1);
    i_a_valid = 0;
    cyc();
    chk("x5_wren", {31'd0, obs_wren}, 32'd1);
    chk("x5_addr", {27'd0, obs_addr}, 32'd5);
    chk("x5_data", obs_data, 32'h1234_5678);
    cyc();
    chk("x5_wren_off", {31'd0, obs_wren}, 32'd0);

    // Issue x7, B writes it two cycles later
    i_issue_valid = 1; i_issue_rd = 7; i_rs1_addr = 7;
    cyc();
    i_issue_valid = 0;
    cyc();
    chk("x7_busy_n1", {31'd0, obs_rs1}, 32'd1);
    i_b_valid = 1; i_b_addr = 7; i_b_data = 32'hDEAD_BEEF;
    cyc();
    chk("x7_b_ready", {31'd0, obs_b_ready}, 32'd1);
    chk("x7_busy_acc", {31'd0, obs_rs1}, 32'd1);
    i_b_valid = 0;
    cyc();
    chk("x7_wren", {31'd0, obs_wren}, 32'd1);
    chk("x7_busy_commit", {31'd0, obs_rs1}, 32'd1);
    cyc();
    chk("x7_busy_clear", {31'd0, obs_rs1}, 32'd0);

    // Both continuously valid: B wins every fifth cycle
    i_a_valid = 1; i_a_addr = 10; i_a_data = 32'hAAAA_0001;
    i_b_valid = 1; i_b_addr = 11; i_b_data = 32'hBBBB_0001;
    pat = 0; both = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      pat[i] = obs_b_ready;
      if (obs_a_ready && obs_b_ready) both++;
    end
    chk("fair_pattern", {22'd0, pat}, 32'b10_0001_0000);
    chk("fair_both", both, 0);
    idle_inputs();
    cyc();

    // Issue x3 on the cycle x3 commits: set wins
    i_a_valid = 1; i_a_addr = 3; i_a_data = 32'h0000_0033;
    cyc();
    i_a_valid = 0; i_issue_valid = 1; i_issue_rd = 3; i_rs1_addr = 3;
    cyc();
    chk("x3_commit_wren", {31'd0, obs_wren}, 32'd1);
    i_issue_valid = 0;
    cyc();
    chk("x3_still_busy", {31'd0, obs_rs1}, 32'd1);

    // x0 write dropped, x0 never busy
    i_a_valid = 1; i_a_addr = 0; i_a_data = 32'hFFFF_FFFF; i_rs1_addr = 0;
    cyc();
    chk("x0_ready", {31'd0, obs_a_ready}, 32'd1);
    i_a_valid = 0; i_issue_valid = 1; i_issue_rd = 0;
    cyc();
    chk("x0_wren", {31'd0, obs_wren}, 32'd0);
    i_issue_valid = 0;
    cyc();
    chk("x0_busy", {31'd0, obs_rs1}, 32'd0);

    // Randomized traffic, held until accepted
    for (int n = 0; n < 3000; n++) begin
      if (!i_a_valid || obs_a_ready) begin
        i_a_valid = ($urandom_range(0, 3) != 0);
        i_a_addr = 5'($urandom_range(0, 31)); i_a_data = $urandom;
      end
      if (!i_b_valid || obs_b_ready) begin
        i_b_valid = ($urandom_range(0, 2) != 0);
        i_b_addr = 5'($urandom_range(0, 31)); i_b_data = $urandom;
      end
      i_issue_valid = ($urandom_range(0, 2) == 0);
      i_issue_rd = 5'($urandom_range(0, 31));
      i_rs1_addr = ($urandom_range(0, 1) == 0) ? o_rd_addr : 5'($urandom_range(0, 31));
      i_rs2_addr = 5'($urandom_range(0, 31));
      cyc();
    end
    idle_inputs();
    cyc();

    // Mid-cycle reset with a pending write, busy x2/x9, and B partly waited
    i_a_valid = 1; i_a_addr = 12; i_a_data = 32'hC0DE_0012;
    i_b_valid = 1; i_b_addr = 13; i_b_data = 32'hC0DE_0013;
    i_rs1_addr = 2; i_rs2_addr = 9;
    i_issue_valid = 1; i_issue_rd = 2;
    cyc();
    i_issue_rd = 9;
    cyc();
    i_issue_valid = 0;
    #3 i_reset = 1;
    #1;
    chk("mrst_wren", {31'd0, o_rd_wren}, 32'd0);
    chk("mrst_addr", {27'd0, o_rd_addr}, 32'd0);
    chk("mrst_data", o_rd_data, 32'd0);
    chk("mrst_busy2", {31'd0, o_rs1_busy}, 32'd0);
    chk("mrst_busy9", {31'd0, o_rs2_busy}, 32'd0);
    model_reset();
    @(posedge i_clk);
    #1 i_reset = 0;
    pat5 = 0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      pat5[i] = obs_b_ready;
    end
    chk("mrst_wait_restart", {27'd0, pat5}, 32'b1_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
